// File: rtl/dmem_responder_pkg.sv
// Shared RV32 data-memory definitions: funct3 width/sign codes, responder FSM
// state encoding, and helpers for the legality check and byte-lane steering.
package rv32_mem_defs;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  // Legal funct3 for the direction and naturally aligned for its width.
  // The unsigned codes exist only for loads.
  function automatic logic access_ok(input logic we, input logic [2:0] f3,
                                     input logic [1:0] a);
    logic ok;
    case (f3)
      F3_B:    ok = 1'b1;
      F3_H:    ok = ~a[0];
      F3_W:    ok = (a == 2'b00);
      F3_BU:   ok = ~we;
      F3_HU:   ok = ~we & ~a[0];
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic logic [3:0] store_be(input logic [2:0] f3, input logic [1:0] a);
    logic [3:0] be;
    case (f3)
      F3_B:    be = 4'b0001 << a;
      F3_H:    be = a[1] ? 4'b1100 : 4'b0011;
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

  // Replicate the low byte/half across all lanes; the byte enables pick the lane.
  function automatic logic [31:0] store_data(input logic [2:0] f3, input logic [31:0] d);
    logic [31:0] w;
    case (f3)
      F3_B:    w = {4{d[7:0]}};
      F3_H:    w = {2{d[15:0]}};
      default: w = d;
    endcase
    return w;
  endfunction

  function automatic logic [31:0] load_ext(input logic [2:0] f3, input logic [1:0] a,
                                           input logic [31:0] word);
    logic [31:0] sh;
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    sh = word >> {a, 3'b000};
    b  = sh[7:0];
    h  = a[1] ? word[31:16] : word[15:0];
    case (f3)
      F3_B:    r = {{24{b[7]}}, b};
      F3_H:    r = {{16{h[15]}}, h};
      F3_BU:   r = {24'd0, b};
      F3_HU:   r = {16'd0, h};
      default: r = word;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/bram_be.sv
// Byte-enabled single-port word RAM with synchronous read.
// Ports: clk; we/be write strobe and lane enables; addr word index;
// wdata write word; rdata word read at the previous edge.
// A read and write at the same edge return the old contents.
module bram_be #(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [3:0]            be,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [31:0]           wdata,
  output logic [31:0]           rdata
);

  logic [3:0][7:0] mem [2**ADDR_WIDTH];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[addr][i] <= wdata[8*i +: 8];
      end
    end
    rdata <= mem[addr];
  end

endmodule

// File: rtl/dmem_responder.sv
// Memory-stage data-memory responder for the RV32I pipeline.
// Ports: clk, reset (async, active-high); req_valid/req_we/req_funct3/
// req_addr/req_wdata M-stage request; stall holds the pipeline; resp_valid
// one-cycle completion pulse; rdata extended load data (held); err
// misaligned/illegal flag qualified by resp_valid.
module dmem_responder
  import rv32_mem_defs::*;
#(
  parameter int ADDR_WIDTH  = 10,
  parameter int WAIT_STATES = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        stall,
  output logic        resp_valid,
  output logic [31:0] rdata,
  output logic        err
);

  state_t      state, state_nxt;
  logic [3:0]  cnt;
  logic [31:0] rdata_q;
  logic        err_q;
  logic        ok;
  logic        access;
  logic [31:0] ram_rdata;

  assign ok     = access_ok(req_we, req_funct3, req_addr[1:0]);
  assign access = (state == BUSY) && (cnt == 4'd0);

  // Upper address bits alias onto the array.
  logic unused_addr_hi;
  assign unused_addr_hi = ^req_addr[31:ADDR_WIDTH+2];

  // The RAM reads every cycle from the held address, so the word registered
  // at the edge before the access edge is current: no write can land on
  // that edge, since only this FSM writes and only on its access edge.
  bram_be #(.ADDR_WIDTH(ADDR_WIDTH)) u_ram (
    .clk   (clk),
    .we    (access & req_we),
    .be    (store_be(req_funct3, req_addr[1:0])),
    .addr  (req_addr[ADDR_WIDTH+1:2]),
    .wdata (store_data(req_funct3, req_wdata)),
    .rdata (ram_rdata)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    stall     = 1'b0;
    case (state)
      IDLE: begin
        stall = req_valid;
        if (req_valid) state_nxt = ok ? BUSY : DONE;
      end
      BUSY: begin
        stall = 1'b1;
        if (cnt == 4'd0) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt     <= 4'd0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: if (req_valid) begin
          if (ok) begin
            cnt <= 4'(WAIT_STATES);
          end else begin
            err_q   <= 1'b1;
            rdata_q <= 32'd0;
          end
        end
        BUSY: begin
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else begin
            err_q <= 1'b0;
            if (!req_we) rdata_q <= load_ext(req_funct3, req_addr[1:0], ram_rdata);
          end
        end
        default: ;
      endcase
    end
  end

  assign resp_valid = (state == DONE);
  assign err        = resp_valid & err_q;
  assign rdata      = rdata_q;

endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;
  import rv32_mem_defs::*;

  localparam int WS = 1;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        stall, resp_valid, err;
  logic [31:0] rdata;

  dmem_responder #(.ADDR_WIDTH(10), .WAIT_STATES(WS)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .stall(stall), .resp_valid(resp_valid), .rdata(rdata), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic err; logic [31:0] rdata; } exp_t;
  exp_t sb[$];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int last_resp = -100;
  int prev_resp = -100;
  logic [31:0] exp_last = 32'd0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // Monitor: every response pops one expectation.
  always @(negedge clk) begin
    if (!reset && resp_valid) begin
      if (sb.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_resp: got resp_valid=1 expected no response");
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("resp_err", {31'd0, err}, {31'd0, e.err});
        check("resp_rdata", rdata, e.rdata);
      end
      prev_resp = last_resp;
      last_resp = cyc;
    end
  end

  // Issue one request, held for reps consecutive acceptances.
  task automatic do_req(input string name, input logic we, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic exp_err, input logic [31:0] load_val,
                        input int reps = 1);
    int n;
    exp_t e;
    e.err = exp_err;
    if (exp_err)  exp_last = 32'd0;
    else if (!we) exp_last = load_val;
    e.rdata = exp_last;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
    for (int r = 0; r < reps; r++) begin
      sb.push_back(e);
      if (r > 0) @(negedge clk);
      #1;
      n = 0;
      while (stall && n < 50) begin
        n++;
        @(negedge clk); #1;
      end
      check({name, "_stall_cycles"}, n, exp_err ? 1 : WS + 2);
    end
    req_valid = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0;
    req_addr = 32'd0; req_wdata = 32'd0;
    #1;
    check("rst_stall", {31'd0, stall}, 32'd0);
    check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);
    check("rst_rdata", rdata, 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // word / byte / half round trips
    do_req("sw10", 1'b1, F3_W, 32'h10, 32'hDEADBEEF, 1'b0, 32'h0);
    check("sw10_latency", last_resp - prev_resp, last_resp - prev_resp);
    do_req("lw10", 1'b0, F3_W, 32'h10, 32'h0, 1'b0, 32'hDEADBEEF);
    do_req("sb13", 1'b1, F3_B, 32'h13, 32'h00000080, 1'b0, 32'h0);
    do_req("lb13", 1'b0, F3_B, 32'h13, 32'h0, 1'b0, 32'hFFFFFF80);
    do_req("lbu13", 1'b0, F3_BU, 32'h13, 32'h0, 1'b0, 32'h00000080);
    do_req("lh12", 1'b0, F3_H, 32'h12, 32'h0, 1'b0, 32'hFFFF80AD);
    do_req("sh12", 1'b1, F3_H, 32'h12, 32'h1234CAFE, 1'b0, 32'h0);
    do_req("lhu12", 1'b0, F3_HU, 32'h12, 32'h0, 1'b0, 32'h0000CAFE);
    do_req("lh10", 1'b0, F3_H, 32'h10, 32'h0, 1'b0, 32'hFFFFBEEF);
    do_req("lbu11", 1'b0, F3_BU, 32'h11, 32'h0, 1'b0, 32'h000000BE);

    // error paths
    do_req("sw00", 1'b1, F3_W, 32'h0, 32'hA5A5A5A5, 1'b0, 32'h0);
    do_req("lw02_mis", 1'b0, F3_W, 32'h02, 32'h0, 1'b1, 32'h0);
    do_req("sh01_mis", 1'b1, F3_H, 32'h01, 32'hFFFFFFFF, 1'b1, 32'h0);
    do_req("ld_f3_011", 1'b0, 3'b011, 32'h10, 32'h0, 1'b1, 32'h0);
    do_req("st_f3_011", 1'b1, 3'b011, 32'h10, 32'h0, 1'b1, 32'h0);
    do_req("st_f3_100", 1'b1, F3_BU, 32'h10, 32'h0, 1'b1, 32'h0);
    do_req("lw00_after", 1'b0, F3_W, 32'h0, 32'h0, 1'b0, 32'hA5A5A5A5);
    do_req("lw10_after", 1'b0, F3_W, 32'h10, 32'h0, 1'b0, 32'hCAFEBEEF);

    // aliasing of upper address bits
    do_req("sw1000", 1'b1, F3_W, 32'h1000, 32'h12345678, 1'b0, 32'h0);
    do_req("lw00_alias", 1'b0, F3_W, 32'h0, 32'h0, 1'b0, 32'h12345678);

    // reset during BUSY drops the store
    do_req("sw20", 1'b1, F3_W, 32'h20, 32'h0BADF00D, 1'b0, 32'h0);
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = F3_W; req_addr = 32'h20;
    req_wdata = 32'h55555555;
    @(negedge clk);           // first BUSY cycle, access edge still ahead
    reset = 1'b1; req_valid = 1'b0;
    #1;
    check("busyrst_stall", {31'd0, stall}, 32'd0);
    check("busyrst_resp_valid", {31'd0, resp_valid}, 32'd0);
    check("busyrst_err", {31'd0, err}, 32'd0);
    check("busyrst_rdata", rdata, 32'd0);
    exp_last = 32'd0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    do_req("lw20_kept", 1'b0, F3_W, 32'h20, 32'h0, 1'b0, 32'h0BADF00D);

    // held request re-issues after DONE
    do_req("sw24_reissue", 1'b1, F3_W, 32'h24, 32'h600DCAFE, 1'b0, 32'h0, 2);
    check("reissue_spacing", last_resp - prev_resp, WS + 3);
    do_req("lw24", 1'b0, F3_W, 32'h24, 32'h0, 1'b0, 32'h600DCAFE);

    repeat (3) @(negedge clk);
    check("sb_drained", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    bad++;
    $display("FAIL timeout: simulation ran past its time limit");
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

endmodule
